// File: rtl/shift_pkg.sv
// Shared definitions for the multi-mode sequential shifter: operation
// codes and FSM state encoding.
package shift_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Purely combinational single-position shift/rotate step. Produces the
// next operand value and the bit that leaves it.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  // One-position step selected by the operation code
  always_comb begin
    nxt     = cur;
    out_bit = cur[0];
    case (op)
      OP_SLL: begin
        nxt     = {cur[WIDTH-2:0], ser_in};
        out_bit = cur[WIDTH-1];
      end
      OP_SRL: begin
        nxt     = {ser_in, cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      OP_SRA: begin
        nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      OP_ROL: begin
        nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
        out_bit = cur[WIDTH-1];
      end
      OP_ROR: begin
        nxt     = {cur[0], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      default: begin
        // LOAD and reserved codes never step; hold the value
        nxt     = cur;
        out_bit = cur[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-mode sequential shifter: loads an operand on start, then shifts or
// rotates it one position per clock for a clamped amount, with a
// start/busy/done handshake. All outputs come straight from registers.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  input  logic             ser_in,
  output logic [WIDTH-1:0] y,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] n_s;
  logic [WIDTH-1:0] step_nxt_s;
  logic             step_out_s;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .ser_in  (ser_in),
    .cur     (y_q),
    .nxt     (step_nxt_s),
    .out_bit (step_out_s)
  );

  // Effective amount: LOAD/reserved force zero, others clamp to WIDTH
  always_comb begin
    n_s = {AMT_W{1'b0}};
    if (op >= OP_LOAD) begin
      n_s = {AMT_W{1'b0}};
    end else if (amt > AMT_W'(WIDTH)) begin
      n_s = AMT_W'(WIDTH);
    end else begin
      n_s = amt;
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    ser_out_d = ser_out_q;
    count_d   = count_q;
    op_d      = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          y_d     = a;
          op_d    = op;
          count_d = n_s;
          if (n_s == {AMT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        y_d       = step_nxt_s;
        ser_out_d = step_out_s;
        count_d   = count_q - {{(AMT_W-1){1'b0}}, 1'b1};
        if (count_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= {WIDTH{1'b0}};
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= {AMT_W{1'b0}};
      op_q      <= OP_LOAD;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      op_q      <= op_d;
    end
  end

  assign y       = y_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit at WIDTH=8.
module tb_shift_unit;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] a;
  logic             ser_in;
  logic [WIDTH-1:0] y;
  logic             ser_out;
  logic             busy;
  logic             done;

  int n_pass;
  int n_total;

  shift_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .a       (a),
    .ser_in  (ser_in),
    .y       (y),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done; report cycles waited and busy cycles seen
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt = bcnt + 1;
      tick();
      cyc = cyc + 1;
    end
  endtask

  // Issue one operation and wait for its done pulse
  task automatic run_op(input logic [2:0] o, input logic [AMT_W-1:0] m,
                        input logic [WIDTH-1:0] d, input logic si,
                        output int cyc, output int bcnt);
    op     = o;
    amt    = m;
    a      = d;
    ser_in = si;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(cyc, bcnt);
  endtask

  int cyc;
  int bcnt;
  int dcnt;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    amt     = '0;
    a       = '0;
    ser_in  = 1'b0;
    tick();
    tick();
    check_eq("rst_y", y, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_done", done, 32'h0);
    check_eq("rst_ser_out", ser_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // SLL 10101010 by 3, fill 1
    run_op(3'b000, 4'd3, 8'hAA, 1'b1, cyc, bcnt);
    check_eq("sll_done", done, 32'h1);
    check_eq("sll_latency", cyc, 32'd3);
    check_eq("sll_busy_cycles", bcnt, 32'd3);
    check_eq("sll_y", y, 32'h57);
    check_eq("sll_ser_out", ser_out, 32'h1);
    tick();
    check_eq("sll_done_single", done, 32'h0);
    tick();
    check_eq("idle_y_hold", y, 32'h57);

    // SRA 11001101 by 2
    run_op(3'b010, 4'd2, 8'hCD, 1'b0, cyc, bcnt);
    check_eq("sra_busy_cycles", bcnt, 32'd2);
    check_eq("sra_y", y, 32'hF3);
    check_eq("sra_ser_out", ser_out, 32'h0);
    tick();
    check_eq("sra_done_single", done, 32'h0);

    // ROR by 10 clamps to 8
    run_op(3'b100, 4'd10, 8'hCD, 1'b0, cyc, bcnt);
    check_eq("ror_busy_cycles", bcnt, 32'd8);
    check_eq("ror_y", y, 32'hCD);
    check_eq("ror_ser_out", ser_out, 32'h1);
    tick();

    // SRL by WIDTH with fill 0
    run_op(3'b001, 4'd8, 8'hCD, 1'b0, cyc, bcnt);
    check_eq("srl_busy_cycles", bcnt, 32'd8);
    check_eq("srl_y", y, 32'h00);
    check_eq("srl_ser_out", ser_out, 32'h1);
    tick();

    // LOAD ignores amt and leaves ser_out alone
    run_op(3'b101, 4'd7, 8'h5A, 1'b0, cyc, bcnt);
    check_eq("load_latency", cyc, 32'd0);
    check_eq("load_busy_cycles", bcnt, 32'd0);
    check_eq("load_y", y, 32'h5A);
    check_eq("load_ser_out", ser_out, 32'h1);
    tick();

    // Reserved code behaves as LOAD
    run_op(3'b111, 4'd3, 8'h3C, 1'b1, cyc, bcnt);
    check_eq("rsvd_latency", cyc, 32'd0);
    check_eq("rsvd_y", y, 32'h3C);
    tick();

    // start mid-RUN is ignored; SLL 0x81 by 4, fill 0 -> 0x10
    op = 3'b000; amt = 4'd4; a = 8'h81; ser_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 3'b100; amt = 4'd1; a = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'b000; a = 8'h00;
    wait_done(cyc, bcnt);
    check_eq("midrun_done", done, 32'h1);
    check_eq("midrun_y", y, 32'h10);
    check_eq("midrun_ser_out", ser_out, 32'h0);

    // Back-to-back: start held in DONE -> ROL 0x96 by 1
    op = 3'b011; amt = 4'd1; a = 8'h96; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b2b_busy", busy, 32'h1);
    tick();
    check_eq("b2b_done", done, 32'h1);
    check_eq("b2b_y", y, 32'h2D);
    check_eq("b2b_ser_out", ser_out, 32'h1);
    tick();

    // Reset during 2nd shift of ROL 0x3C by 5
    op = 3'b011; amt = 4'd5; a = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mrst_y", y, 32'h0);
    check_eq("mrst_busy", busy, 32'h0);
    check_eq("mrst_done", done, 32'h0);
    check_eq("mrst_ser_out", ser_out, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dcnt = dcnt + 1;
    end
    check_eq("mrst_no_activity", dcnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
Parametrised multi-mode sequential shifter, the successor to the fixed 8-bit serial shift register in the ALU datapath. It loads a WIDTH-bit operand, then performs logical, arithmetic or rotate shifts one position per clock for a requested amount. A start/busy/done handshake lets the ALU controller issue multi-bit shifts without external sequencing. A serial input fills vacated bits, and a serial output reports the last bit shifted out.

Parameters:
WIDTH, 8, operand/result width (>=2)
AMT_W, $clog2(WIDTH)+1, width of shift-amount port (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE or DONE
op  input  3  operation code (see Behaviour)
amt  input  AMT_W  shift amount, unsigned
a  input  WIDTH  operand, captured on accepted start
ser_in  input  1  fill bit for SLL/SRL
y  output  WIDTH  result register
ser_out  output  1  last bit shifted out
busy  output  1  high while shifting
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: rst_n sampled low at a rising edge -> state IDLE, y=0, ser_out=0, busy=0, done=0, internal count=0. Reset overrides start and an in-progress shift. No partial result is retained.
- op encoding:
  - 000 SLL: shift left, fill with ser_in.
  - 001 SRL: shift right, fill with ser_in.
  - 010 SRA: shift right, fill with MSB.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101 LOAD: load only; amt is ignored and treated as 0.
  - 110/111 reserved: behave as LOAD.
- Amount clamp: effective amount n = min(amt, WIDTH). ROL/ROR by WIDTH returns the operand; SLL/SRL by WIDTH returns all ser_in; SRA by WIDTH returns all MSB.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are registered.
- Accept at edge k when start=1 in IDLE or DONE:
  - y <= a; op latched; count <= n.
  - n==0 -> next state DONE; otherwise -> next state RUN.
- RUN, per edge:
  - y <= one-position step of y per the latched op.
  - ser_out <= bit leaving y: MSB for SLL/ROL, LSB for SRL/SRA/ROR.
  - count decrements by 1; when count==1 before the edge -> next state DONE.
- Timing: n shifts occupy edges k+1..k+n. done is high in the cycle after edge k+n, for exactly one cycle. busy is high for exactly n cycles.
- DONE: start=1 at this edge begins a new operation (back-to-back, no bubble). Otherwise -> IDLE.
- start in RUN: ignored, no effect on op, count or y. Inputs a/op/amt/ser_in may change freely during RUN; ser_in is sampled live each shift edge.
- y holds its value in IDLE/DONE until the next accepted start. ser_out holds the last shifted-out bit; LOAD does not change ser_out.
- All outputs are driven from registers; no combinational input-to-output path.

Decomposition:
- shared package shift_pkg:
  - op code localparams OP_SLL..OP_LOAD.
  - FSM state encoding ST_IDLE/ST_RUN/ST_DONE.
- sub-module shift_step: purely combinational single-position step.
  - Inputs: op, ser_in, cur[WIDTH].
  - Outputs: nxt[WIDTH], out_bit.
  - Instantiated once inside shift_unit; all registers and the FSM remain in shift_unit.

Test Plan:
- WIDTH=8, SLL, a=10101010, amt=3, ser_in=1 -> busy high 3 cycles; done pulse in the 4th cycle after the start edge; y=01010111, ser_out=1.
- SRA, a=11001101, amt=2 -> y=11110011, ser_out=0, busy 2 cycles, then single done pulse.
- ROR, a=11001101, amt=10 (clamped to 8) -> busy exactly 8 cycles, y=11001101; then SRL ser_in=0 amt=8 -> y=00000000.
- LOAD, a=0x5A, amt=7 -> busy never asserted; done one cycle after the start edge; y=0x5A; ser_out unchanged.
- start pulsed mid-RUN with different a/op -> ignored, original result intact. start held high in DONE -> new op accepted with no idle cycle.
- rst_n low for one edge during the 2nd shift of ROL amt=5 -> next cycle y=0, busy=0, done=0, ser_out=0; no done pulse follows.
